// File: rtl/kuznechik_key_store.sv
// Kuznechik round-key register file: pair capture, key streaming, random read.
// Optional reverse-order streaming via `define KEY_STORE_DECRYPT_EN.
module kuznechik_key_store #(
  parameter int KEY_W    = 128,
  parameter int NUM_KEYS = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load_key,
  input  logic [2*KEY_W-1:0] i_load_pair,
  input  logic               i_load_done,
  input  logic               i_clear,
  input  logic               i_start,
`ifdef KEY_STORE_DECRYPT_EN
  input  logic               i_decrypt,
`endif
  output logic [KEY_W-1:0]   o_key_out,
  output logic [3:0]         o_key_idx,
  output logic               o_key_valid,
  output logic               o_keys_ready,
  output logic               o_busy,
  input  logic [3:0]         i_rd_idx,
  output logic [KEY_W-1:0]   o_rd_key,
  output logic               o_err
);

  localparam int NP = NUM_KEYS / 2;
  localparam int CW = $clog2(NP + 1);
  localparam logic [CW-1:0] NPC  = CW'(NP);
  localparam logic [3:0]    NK4  = 4'(NUM_KEYS);
  localparam logic [3:0]    LAST = 4'(NUM_KEYS - 1);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_FULL   = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t            r_state, w_state_n;
  logic [CW-1:0]     r_cnt, w_cnt_n, w_cnt_ld;
  logic              r_err, w_err_n;
  logic [3:0]        r_sidx, w_sidx_n;
  logic              r_dec, w_dec_n, w_dec;
  logic [KEY_W-1:0]  r_key_out, w_out_n;
  logic [3:0]        r_key_idx, w_idx_n;
  logic              r_key_valid, w_valid_n;
  logic              w_wr;
  logic [3:0]        w_wa, w_first_idx, w_next_idx;
  logic [KEY_W-1:0]  r_keys [NUM_KEYS];
  logic [KEY_W-1:0]  r_rd_key;

`ifdef KEY_STORE_DECRYPT_EN
  assign w_dec = i_decrypt;
`else
  assign w_dec = 1'b0;
`endif

  assign w_cnt_ld    = r_cnt + (i_load_key ? CW'(1) : CW'(0));
  assign w_wa        = 4'({r_cnt, 1'b0});
  assign w_first_idx = w_dec ? LAST : 4'd0;
  assign w_next_idx  = r_dec ? (LAST - r_sidx) : r_sidx;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_err_n   = r_err;
    w_sidx_n  = r_sidx;
    w_dec_n   = r_dec;
    w_out_n   = '0;
    w_idx_n   = '0;
    w_valid_n = 1'b0;
    w_wr      = 1'b0;
    if (i_clear) begin
      w_state_n = S_EMPTY;
      w_cnt_n   = '0;
      w_err_n   = 1'b0;
      w_sidx_n  = '0;
    end else begin
      unique case (r_state)
        S_EMPTY: begin
          if (i_load_key) begin
            w_wr    = 1'b1;
            w_cnt_n = w_cnt_ld;
            if (w_cnt_ld == NPC) w_state_n = S_FULL;
          end
          if (i_load_done && (w_cnt_ld < NPC)) w_err_n = 1'b1;
        end
        S_FULL: begin
          if (i_load_key) begin
            w_err_n = 1'b1;
          end else if (i_start && !i_load_done) begin
            w_state_n = S_STREAM;
            w_dec_n   = w_dec;
            w_sidx_n  = 4'd1;
            w_valid_n = 1'b1;
            w_idx_n   = w_first_idx;
            w_out_n   = r_keys[w_first_idx];
          end
        end
        S_STREAM: begin
          if (i_load_key) w_err_n = 1'b1;
          // r_sidx counts keys already presented; stop after the last one
          if (r_sidx == NK4) begin
            w_state_n = S_FULL;
            w_sidx_n  = '0;
          end else begin
            w_sidx_n  = r_sidx + 4'd1;
            w_valid_n = 1'b1;
            w_idx_n   = w_next_idx;
            w_out_n   = r_keys[w_next_idx];
          end
        end
        default: w_state_n = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_EMPTY;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_sidx      <= '0;
      r_dec       <= 1'b0;
      r_key_out   <= '0;
      r_key_idx   <= '0;
      r_key_valid <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_err       <= w_err_n;
      r_sidx      <= w_sidx_n;
      r_dec       <= w_dec_n;
      r_key_out   <= w_out_n;
      r_key_idx   <= w_idx_n;
      r_key_valid <= w_valid_n;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_keys[w_wa]        <= i_load_pair[2*KEY_W-1:KEY_W];
      r_keys[w_wa + 4'd1] <= i_load_pair[KEY_W-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                r_rd_key <= '0;
    else if (i_rd_idx < NK4)  r_rd_key <= r_keys[i_rd_idx];
    else                      r_rd_key <= '0;
  end

  assign o_key_out    = r_key_out;
  assign o_key_idx    = r_key_idx;
  assign o_key_valid  = r_key_valid;
  assign o_keys_ready = (r_state != S_EMPTY);
  assign o_busy       = (r_state == S_STREAM);
  assign o_rd_key     = r_rd_key;
  assign o_err        = r_err;

endmodule

// File: tb/tb_kuznechik_key_store.sv
// Scoreboard bench for kuznechik_key_store: loading, streaming, errors,
// clear, random read and reset; reverse stream when KEY_STORE_DECRYPT_EN.
module tb_kuznechik_key_store;

  logic         clk = 1'b0;
  logic         rst, load_key, load_done, clear, start, dec;
  logic [255:0] load_pair;
  logic [3:0]   rd_idx;
  logic [127:0] key_out, rd_key;
  logic [3:0]   key_idx;
  logic         key_valid, keys_ready, busy, err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int           c;
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;
  exp_t q[$];

  kuznechik_key_store #(.KEY_W(128), .NUM_KEYS(10)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_load_key(load_key), .i_load_pair(load_pair),
    .i_load_done(load_done), .i_clear(clear), .i_start(start),
`ifdef KEY_STORE_DECRYPT_EN
    .i_decrypt(dec),
`endif
    .o_key_out(key_out), .o_key_idx(key_idx), .o_key_valid(key_valid),
    .o_keys_ready(keys_ready), .o_busy(busy),
    .i_rd_idx(rd_idx), .o_rd_key(rd_key), .o_err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Key K(n), 1-based
  function automatic logic [127:0] A(input int n);
    return {32'hA5A5_0000 | 32'(n), 32'h0123_4567 + 32'(n),
            32'hDEAD_0000 + 32'(n * 16), 32'(n)};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input int n, input logic done, input int base);
    load_key  = 1'b1;
    load_done = done;
    load_pair = {A(base + 2*n + 1), A(base + 2*n + 2)};
    tick();
    load_key  = 1'b0;
    load_done = 1'b0;
  endtask

  // Start a stream; push nexp expected keys (reversed when d)
  task automatic go(input logic d, input int nexp);
    exp_t e;
    int   s;
    s = cyc;
    for (int i = 0; i < nexp; i++) begin
      e.c   = s + 1 + i;
      e.idx = d ? 4'(9 - i) : 4'(i);
      e.key = A(d ? 10 - i : i + 1);
      q.push_back(e);
    end
    start = 1'b1;
    dec   = d;
    tick();
    start = 1'b0;
    dec   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk("stream_ends", {127'd0, busy}, 128'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (key_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_key: idx %0d key %0h at cyc %0d",
                 key_idx, key_out, cyc);
      end else begin
        e = q.pop_front();
        if (e.c != cyc || e.idx !== key_idx || e.key !== key_out) begin
          errors++;
          $display("FAIL stream_key: got cyc %0d idx %0d key %0h expected cyc %0d idx %0d key %0h",
                   cyc, key_idx, key_out, e.c, e.idx, e.key);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; load_key = 1'b0; load_done = 1'b0; clear = 1'b0;
    start = 1'b0; dec = 1'b0; load_pair = '0; rd_idx = 4'd0;
    tick(); tick();
    chk("rst_keys_ready", {127'd0, keys_ready}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_err", {127'd0, err}, 128'd0);
    chk("rst_key_out", key_out, 128'd0);
    chk("rst_key_idx", {124'd0, key_idx}, 128'd0);
    chk("rst_rd_key", rd_key, 128'd0);
    rst = 1'b0;
    tick();

    for (int n = 0; n < 4; n++) load(n, 1'b0, 0);
    chk("ready_after_4", {127'd0, keys_ready}, 128'd0);
    load(4, 1'b1, 0);
    chk("ready_after_5", {127'd0, keys_ready}, 128'd1);
    chk("err_after_load", {127'd0, err}, 128'd0);

    rd_idx = 4'd7;  tick(); chk("rd7", rd_key, A(8));
    rd_idx = 4'd12; tick(); chk("rd12", rd_key, 128'd0);
    rd_idx = 4'd0;  tick(); chk("rd0", rd_key, A(1));
    rd_idx = 4'd9;  tick(); chk("rd9", rd_key, A(10));

    go(1'b0, 10);
    chk("busy_after_start", {127'd0, busy}, 128'd1);
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    while (cyc < q[$].c) tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_dropped", {127'd0, busy}, 128'd0);
    tick(); tick();
    chk("no_restart", {127'd0, busy}, 128'd0);
    chk("ready_kept", {127'd0, keys_ready}, 128'd1);

    load_key = 1'b1; load_pair = {2{128'hBAD}}; tick(); load_key = 1'b0;
    chk("err_6th_load", {127'd0, err}, 128'd1);
    chk("ready_6th_load", {127'd0, keys_ready}, 128'd1);
    rd_idx = 4'd0; tick(); chk("rd0_kept", rd_key, A(1));
    rd_idx = 4'd1; tick(); chk("rd1_kept", rd_key, A(2));
    chk("err_sticky", {127'd0, err}, 128'd1);

    go(1'b0, 4);
    tick(); tick(); tick();
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_valid", {127'd0, key_valid}, 128'd0);
    chk("clr_busy", {127'd0, busy}, 128'd0);
    chk("clr_ready", {127'd0, keys_ready}, 128'd0);
    chk("clr_err", {127'd0, err}, 128'd0);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("start_empty_ignored", {127'd0, busy}, 128'd0);

    for (int n = 0; n < 3; n++) load(n, 1'b0, 0);
    load_done = 1'b1; tick(); load_done = 1'b0;
    chk("early_done_err", {127'd0, err}, 128'd1);
    chk("early_done_ready", {127'd0, keys_ready}, 128'd0);

    clear = 1'b1; tick(); clear = 1'b0;
    for (int n = 0; n < 5; n++) load(n, 1'b0, 0);
    load_done = 1'b1; tick(); load_done = 1'b0;
    chk("reload_ready", {127'd0, keys_ready}, 128'd1);
    chk("late_done_err", {127'd0, err}, 128'd0);

`ifdef KEY_STORE_DECRYPT_EN
    go(1'b1, 10);
    wait_idle();
    go(1'b1, 3);
`else
    go(1'b0, 3);
`endif
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_mid_valid", {127'd0, key_valid}, 128'd0);
    chk("rst_mid_busy", {127'd0, busy}, 128'd0);
    chk("rst_mid_ready", {127'd0, keys_ready}, 128'd0);
    chk("rst_mid_key", key_out, 128'd0);
    chk("rst_mid_idx", {124'd0, key_idx}, 128'd0);
    chk("rst_mid_rd", rd_key, 128'd0);
    tick(); tick();
    chk("queue_empty", 128'(q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
